// File: rtl/sim_pkg.sv
// Shared types and constants for the block-similarity controller.
package sim_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    // Sum of n results of at most 255 each fits without overflow.
    function automatic int unsigned acc_width(input int unsigned n);
        return PIX_W + $clog2(n);
    endfunction

endpackage

// File: rtl/sim_acc.sv
// Valid-gated block sum and minimum tracker with synchronous clear.
module sim_acc
    import sim_pkg::*;
#(
    parameter int unsigned ACC_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld,
    input  logic [PIX_W-1:0] res,
    output logic [ACC_W-1:0] sum,
    output logic [PIX_W-1:0] min_res
);

    logic [ACC_W-1:0] sum_q;
    logic [PIX_W-1:0] min_q;

    // Clear wins: a block start presets min to the largest value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            min_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
            min_q <= '1;
        end else if (vld) begin
            sum_q <= sum_q + ACC_W'(res);
            if (res < min_q) begin
                min_q <= res;
            end
        end
    end

    assign sum     = sum_q;
    assign min_res = min_q;

endmodule

// File: rtl/sim_block_ctrl.sv
// Sequences one block of N pixel-pair reads through the similarity datapath
// and accumulates the block sum and minimum.
module sim_block_ctrl
    import sim_pkg::*;
#(
    parameter  int unsigned N       = 64,
    parameter  int unsigned AW      = 10,
    parameter  int unsigned MEM_LAT = 1,
    parameter  int unsigned DP_LAT  = 1,
    localparam int unsigned ACC_W   = acc_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    a_base,
    input  logic [AW-1:0]    b_base,
    input  logic             hold,
    output logic [AW-1:0]    a_addr,
    output logic [AW-1:0]    b_addr,
    output logic             rd_en,
    input  logic [PIX_W-1:0] a_data,
    input  logic [PIX_W-1:0] b_data,
    output logic [PIX_W-1:0] dp_op1,
    output logic [PIX_W-1:0] dp_op2,
    input  logic [PIX_W-1:0] dp_res,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sim_sum,
    output logic [PIX_W-1:0] sim_min
);

    localparam int unsigned DEPTH = MEM_LAT + 1 + DP_LAT;
    localparam int unsigned KW    = $clog2(N);

    state_e           state_q, state_d;
    logic [AW-1:0]    a_base_q, b_base_q;
    logic [KW-1:0]    k_q, k_d;
    logic [DEPTH-1:0] vld_q;
    logic [PIX_W-1:0] op1_q, op2_q;
    logic             start_acc;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_en     = 1'b0;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    k_d       = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (!hold) begin
                    rd_en = 1'b1;
                    k_d   = k_q + KW'(1);
                    if (k_q == KW'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            // Leave once only the final stage can still be occupied, so its
            // accumulate lands on the same edge that enters DONE.
            DRAIN: begin
                if (vld_q[DEPTH-2:0] == '0) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            vld_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            vld_q   <= {vld_q[DEPTH-2:0], rd_en};
            if (start_acc) begin
                a_base_q <= a_base;
                b_base_q <= b_base;
            end
        end
    end

    // Memory data for a read is present while its token sits at index MEM_LAT-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op1_q <= '0;
            op2_q <= '0;
        end else if (vld_q[MEM_LAT-1]) begin
            op1_q <= a_data;
            op2_q <= b_data;
        end
    end

    assign a_addr = a_base_q + AW'(k_q);
    assign b_addr = b_base_q + AW'(k_q);
    assign dp_op1 = op1_q;
    assign dp_op2 = op2_q;
    assign busy   = (state_q == RUN) || (state_q == DRAIN);
    assign done   = (state_q == DONE);

    sim_acc #(
        .ACC_W (ACC_W)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (start_acc),
        .vld     (vld_q[DEPTH-1]),
        .res     (dp_res),
        .sum     (sim_sum),
        .min_res (sim_min)
    );

endmodule
